// File: rtl/cfg_region_lookup.sv
// Classifies a physical address against the execute/cached/non-idempotent rule tables, one rule index per cycle.
// Fixed latency N+1 cycles from acceptance; the result is held until rsp_ready_i, and flush_i aborts at any point.
package config_pkg;
  typedef struct packed {
    int unsigned   NrNonIdempotentRules;
    logic [1023:0] NonIdempotentAddrBase;
    logic [1023:0] NonIdempotentLength;
    int unsigned   NrExecuteRegionRules;
    logic [1023:0] ExecuteRegionAddrBase;
    logic [1023:0] ExecuteRegionLength;
    int unsigned   NrCachedRegionRules;
    logic [1023:0] CachedRegionAddrBase;
    logic [1023:0] CachedRegionLength;
    bit            NonIdemPotenceEn;
  } cva6_cfg_t;
endpackage

package cva6_config_pkg;
  localparam config_pkg::cva6_cfg_t cva6_cfg = '{
    NrNonIdempotentRules:  32'd1,
    NonIdempotentAddrBase: 1024'h0,
    NonIdempotentLength:   1024'h1_0000_0000,
    NrExecuteRegionRules:  32'd3,
    ExecuteRegionAddrBase: {{13{64'h0}}, 64'h8000_0000, 64'h1_0000, 64'h0},
    ExecuteRegionLength:   {{13{64'h0}}, 64'h4000_0000, 64'h1_0000, 64'h1000},
    NrCachedRegionRules:   32'd1,
    // Slot 1 is deliberately populated but lies beyond the rule count.
    CachedRegionAddrBase:  {{14{64'h0}}, 64'h0, 64'h8000_0000},
    CachedRegionLength:    {{14{64'h0}}, 64'h2_0000, 64'h4000_0000},
    NonIdemPotenceEn:      1'b0
  };
endpackage

module cfg_region_lookup #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg   = cva6_config_pkg::cva6_cfg,
  parameter int unsigned           AddrWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_exec_o,
  output logic                 rsp_cached_o,
  output logic                 rsp_nonidem_o
);

  localparam int unsigned NrExec    = CVA6Cfg.NrExecuteRegionRules;
  localparam int unsigned NrCached  = CVA6Cfg.NrCachedRegionRules;
  localparam int unsigned NrNonIdem = CVA6Cfg.NrNonIdempotentRules;
  localparam int unsigned NTmp      = (NrExec > NrCached) ? NrExec : NrCached;
  localparam int unsigned N         = (NTmp > NrNonIdem) ? NTmp : NrNonIdem;
  localparam int unsigned KW        = (N > 0) ? $clog2(N + 1) : 1;
  localparam logic [KW-1:0] KLast   = KW'((N > 0) ? (N - 1) : 0);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [KW-1:0]        k_q;
  logic                 exec_q, cached_q, nonidem_q;
  logic                 req_ready_q, rsp_valid_q;

  logic [63:0] addr_ext;
  int unsigned k_idx;
  logic        exec_hit_d, cached_hit_d, nonidem_hit_d;

  // Subtract-then-compare stays correct when base + length wraps past 2^64.
  function automatic logic rule_hit(input logic [63:0]   addr,
                                    input logic [1023:0] bases,
                                    input logic [1023:0] lens,
                                    input int unsigned   idx);
    logic [63:0] base;
    logic [63:0] len;
    base = bases[64*idx +: 64];
    len  = lens[64*idx +: 64];
    return (addr >= base) && ((addr - base) < len);
  endfunction

  assign addr_ext = 64'(addr_q);
  assign k_idx    = 32'(k_q);

  assign exec_hit_d    = (k_idx < NrExec) &&
                         rule_hit(addr_ext, CVA6Cfg.ExecuteRegionAddrBase, CVA6Cfg.ExecuteRegionLength, k_idx);
  assign cached_hit_d  = (k_idx < NrCached) &&
                         rule_hit(addr_ext, CVA6Cfg.CachedRegionAddrBase, CVA6Cfg.CachedRegionLength, k_idx);
  assign nonidem_hit_d = (k_idx < NrNonIdem) &&
                         rule_hit(addr_ext, CVA6Cfg.NonIdempotentAddrBase, CVA6Cfg.NonIdempotentLength, k_idx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      k_q         <= '0;
      exec_q      <= 1'b0;
      cached_q    <= 1'b0;
      nonidem_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && !flush_i) begin
            addr_q      <= req_addr_i;
            k_q         <= '0;
            exec_q      <= 1'b0;
            cached_q    <= 1'b0;
            nonidem_q   <= 1'b0;
            req_ready_q <= 1'b0;
            if (N == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          if (flush_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            exec_q    <= exec_q | exec_hit_d;
            cached_q  <= cached_q | cached_hit_d;
            nonidem_q <= nonidem_q | nonidem_hit_d;
            k_q       <= k_q + 1'b1;
            if (k_q == KLast) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        RESP: begin
          if (flush_i || rsp_ready_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Flags accumulate during SCAN, so they are masked until the result is presented.
  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_exec_o    = rsp_valid_q & exec_q;
  assign rsp_cached_o  = rsp_valid_q & cached_q;
  assign rsp_nonidem_o = rsp_valid_q & nonidem_q & CVA6Cfg.NonIdemPotenceEn;

endmodule

// File: doc/cfg_region_lookup.md
CFG_REGION_LOOKUP -- requirements
Module: cfg_region_lookup

Interface
REQ-001 SHALL have parameter CVA6Cfg, default cva6_config_pkg::cva6_cfg, the config_pkg::cva6_cfg_t record that supplies the region rule tables.
REQ-002 SHALL have parameter AddrWidth, default 64, the lookup address width (at most 64).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush_i, input, 1 bit: aborts an in-flight lookup.
REQ-006 SHALL have port req_valid_i, input, 1 bit: lookup request valid.
REQ-007 SHALL have port req_ready_o, output, 1 bit: the block accepts a request.
REQ-008 SHALL have port req_addr_i, input, AddrWidth bits: the physical address to classify.
REQ-009 SHALL have port rsp_valid_o, output, 1 bit: the result is valid.
REQ-010 SHALL have port rsp_ready_i, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port rsp_exec_o, output, 1 bit: the address lies in an execute region.
REQ-012 SHALL have port rsp_cached_o, output, 1 bit: the address lies in a cached region.
REQ-013 SHALL have port rsp_nonidem_o, output, 1 bit: the address lies in a non-idempotent region.

Function
REQ-014 SHALL implement an FSM with three states: IDLE, SCAN, RESP.
REQ-015 SHALL drive req_ready_o = 1 only in IDLE and rsp_valid_o = 1 only in RESP.
REQ-016 SHALL accept a request in IDLE when req_valid_i = 1 on a clock edge:
- latch req_addr_i;
- clear the three sticky match flags;
- clear the rule index k;
- go to SCAN, or directly to RESP when N = 0.
REQ-017 SHALL define N = max(NrExecuteRegionRules, NrCachedRegionRules, NrNonIdempotentRules).
REQ-018 SHALL in each SCAN cycle evaluate rule k of all three tables in parallel, and OR each result into the matching flag.
REQ-019 SHALL ignore rule k of any table whose rule count is less than or equal to k.
REQ-020 SHALL extract rule k base and length from bits [64*k +: 64] of the 1024-bit base and length fields.
REQ-021 SHALL treat a rule as matching iff addr >= base and (addr - base) < length, compared unsigned over 64 bits:
- the form is free of overflow, so base + length wrapping past 2^64 still covers the tail;
- length = 0 never matches.
REQ-022 SHALL zero-extend the latched address to 64 bits before comparing.
REQ-023 SHALL increment k once per SCAN cycle and go to RESP after the cycle with k = N-1; k is $clog2(N+1) bits and never wraps.
REQ-024 SHALL give deterministic latency: with acceptance in cycle 0, rsp_valid_o rises in cycle N+1 and is independent of the address.
REQ-025 SHALL in RESP drive rsp_* from the flags, holding them stable while rsp_ready_i = 0.
REQ-026 SHALL return to IDLE on an edge with rsp_valid_o & rsp_ready_i.
REQ-027 SHALL NOT accept a new request in the same cycle a response is taken; the next acceptance is the earliest cycle after.
REQ-028 SHALL force rsp_nonidem_o = 0 when CVA6Cfg.NonIdemPotenceEn = 0.
REQ-029 SHALL handle flush_i = 1 as follows:
- in SCAN or RESP: go to IDLE on the next edge, discarding the result; no rsp handshake occurs;
- in IDLE: no request is accepted that cycle.
REQ-030 SHALL let flush_i win when it is asserted together with an rsp handshake; the FSM goes to IDLE either way.
REQ-031 SHALL drive rsp_exec_o, rsp_cached_o and rsp_nonidem_o to 0 whenever rsp_valid_o = 0.
REQ-032 SHALL have no combinational path from req_* to rsp_*; rsp_valid_o depends only on registered state.

Reset
REQ-033 SHALL, on a clock edge with rst_i = 1 in any state including mid-SCAN:
- enter IDLE;
- clear k, the flags and the address register;
- drive req_ready_o = 1, rsp_valid_o = 0 and all rsp flags = 0 from the following cycle.
REQ-034 SHALL give rst_i priority over flush_i and over both handshakes.

Verification (default config: N = 3; exec {0x0/0x1000, 0x1_0000/0x10000, 0x8000_0000/0x4000_0000}; cached {0x8000_0000/0x4000_0000}; NonIdemPotenceEn = 0)
REQ-035 SHALL test the DRAM hit: addr 0x8000_1000, rsp_ready_i = 1 -> rsp_valid_o in cycle 4, exec = 1, cached = 1, nonidem = 0, one-cycle pulse.
REQ-036 SHALL test region boundaries:
- 0x0FFF -> exec = 1, cached = 0;
- 0x1000 -> exec = 0;
- 0x1_0000 -> exec = 1, cached = 0;
- 0xBFFF_FFFF -> exec = 1, cached = 1;
- 0xC000_0000 -> exec = 0, cached = 0.
REQ-037 SHALL test backpressure: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and flags stay constant and req_ready_o = 0; a handshake on cycle 6 returns to IDLE and the next request is accepted no earlier than the following cycle.
REQ-038 SHALL test flush and reset mid-operation: flush_i or rst_i asserted at SCAN k = 1 -> IDLE next cycle, no rsp_valid_o pulse, req_ready_o = 1; the next lookup returns correct flags.
REQ-039 SHALL test the wrap and empty-table cases with an override config:
- exec rule base 0xFFFF_FFFF_FFFF_F000, length 0x2000: addr 0xFFFF_FFFF_FFFF_FFFF -> exec = 1, addr 0x0 -> exec = 0;
- all rule counts 0: rsp_valid_o in cycle 1 with all flags 0.
